// File: rtl/ext_arbiter_pkg.sv
// ext_arbiter_pkg
// Shared constants and types for the immediate-extension arbiter.
//   OWNER_A / OWNER_B        : requester ids carried on owner_out and last_owner
//   NARROW_FIELD_WIDTH       : width of the narrow immediate field (bits [3:0])
//   REGISTER_DATA_BIT_WIDTH  : register width, shared with the register file and ALU
//   EXT_FIELD_WIDTH          : width of the raw field inputs
//   arb_state_t              : output register occupancy (EMPTY / FULL)
package ext_arbiter_pkg;

  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

  localparam int NARROW_FIELD_WIDTH      = 4;
  localparam int REGISTER_DATA_BIT_WIDTH = 16;
  localparam int EXT_FIELD_WIDTH         = 8;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } arb_state_t;

endpackage : ext_arbiter_pkg

// File: rtl/ext_arbiter_datapath.sv
// ext_datapath
// Combinational immediate extension.
//   field    in  FIELD_WIDTH  raw immediate field
//   wide     in  1            0 = use field[3:0], 1 = use the full field
//   sign_ext in  1            1 = sign-extend, 0 = zero-extend
//   result   out DATA_WIDTH   extended value
module ext_datapath
  import ext_arbiter_pkg::*;
#(
  parameter int FIELD_WIDTH = EXT_FIELD_WIDTH,
  parameter int DATA_WIDTH  = REGISTER_DATA_BIT_WIDTH
) (
  input  logic [FIELD_WIDTH-1:0] field,
  input  logic                   wide,
  input  logic                   sign_ext,
  output logic [DATA_WIDTH-1:0]  result
);

  logic fill_wide;
  logic fill_narrow;

  // Fill bit is the selected source's MSB only when sign-extending.
  assign fill_wide   = sign_ext & field[FIELD_WIDTH-1];
  assign fill_narrow = sign_ext & field[NARROW_FIELD_WIDTH-1];

  always_comb begin
    result = '0;
    if (wide) begin
      result = {{(DATA_WIDTH-FIELD_WIDTH){fill_wide}}, field};
    end else begin
      result = {{(DATA_WIDTH-NARROW_FIELD_WIDTH){fill_narrow}},
                field[NARROW_FIELD_WIDTH-1:0]};
    end
  end

endmodule : ext_datapath

// File: rtl/ext_arbiter.sv
// ext_arbiter
// Two-requester round-robin front end to one shared immediate extender with a
// one-entry registered output that holds under backpressure.
//   clk, reset              : system clock, synchronous active-high reset
//   req_x / gnt_x           : request / combinational grant for A and B
//   field_x, wide_x, signed_x : extension operands of each requester
//   out_ready               : downstream takes data_out this cycle
//   valid_out, data_out, owner_out : registered result and its owner
//
// state    | meaning
// ST_EMPTY | no result held; any request is accepted
// ST_FULL  | result held; accepts only when out_ready drains it the same edge
module ext_arbiter
  import ext_arbiter_pkg::*;
#(
  parameter int REGISTER_DATA_BIT_WIDTH = ext_arbiter_pkg::REGISTER_DATA_BIT_WIDTH,
  parameter int FIELD_WIDTH             = EXT_FIELD_WIDTH
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               req_a,
  input  logic [FIELD_WIDTH-1:0]             field_a,
  input  logic                               wide_a,
  input  logic                               signed_a,
  input  logic                               req_b,
  input  logic [FIELD_WIDTH-1:0]             field_b,
  input  logic                               wide_b,
  input  logic                               signed_b,
  output logic                               gnt_a,
  output logic                               gnt_b,
  input  logic                               out_ready,
  output logic                               valid_out,
  output logic [REGISTER_DATA_BIT_WIDTH-1:0] data_out,
  output logic                               owner_out
);

  arb_state_t state_q;
  arb_state_t state_d;
  logic       last_owner;
  logic       accept;
  logic       load;

  logic [FIELD_WIDTH-1:0]             sel_field;
  logic                               sel_wide;
  logic                               sel_signed;
  logic [REGISTER_DATA_BIT_WIDTH-1:0] ext_result;

  assign valid_out = (state_q == ST_FULL);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Grants never look at field inputs, so the field mux below cannot loop
  // back into arbitration.
  always_comb begin
    state_d = state_q;
    gnt_a   = 1'b0;
    gnt_b   = 1'b0;
    accept  = (state_q == ST_EMPTY) || out_ready;
    if (!reset && accept) begin
      if (req_a && req_b) begin
        gnt_a = (last_owner == OWNER_B);
        gnt_b = (last_owner == OWNER_A);
      end else begin
        gnt_a = req_a;
        gnt_b = req_b;
      end
    end
    load = gnt_a || gnt_b;
    case (state_q)
      ST_EMPTY: if (load) state_d = ST_FULL;
      ST_FULL:  if (out_ready && !load) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_comb begin
    sel_field  = gnt_b ? field_b  : field_a;
    sel_wide   = gnt_b ? wide_b   : wide_a;
    sel_signed = gnt_b ? signed_b : signed_a;
  end

  ext_datapath #(
    .FIELD_WIDTH (FIELD_WIDTH),
    .DATA_WIDTH  (REGISTER_DATA_BIT_WIDTH)
  ) u_datapath (
    .field    (sel_field),
    .wide     (sel_wide),
    .sign_ext (sel_signed),
    .result   (ext_result)
  );

  // Reset leaves last_owner at B so that A wins the first contention.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out   <= '0;
      owner_out  <= OWNER_A;
      last_owner <= OWNER_B;
    end else if (load) begin
      data_out   <= ext_result;
      owner_out  <= gnt_b;
      last_owner <= gnt_b;
    end
  end

endmodule : ext_arbiter

// File: tb/tb_ext_arbiter.sv
module tb_ext_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_a, req_b;
  logic [7:0]  field_a, field_b;
  logic        wide_a, wide_b;
  logic        signed_a, signed_b;
  logic        gnt_a, gnt_b;
  logic        out_ready;
  logic        valid_out;
  logic [15:0] data_out;
  logic        owner_out;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ext_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req_a     (req_a),
    .field_a   (field_a),
    .wide_a    (wide_a),
    .signed_a  (signed_a),
    .req_b     (req_b),
    .field_b   (field_b),
    .wide_b    (wide_b),
    .signed_b  (signed_b),
    .gnt_a     (gnt_a),
    .gnt_b     (gnt_b),
    .out_ready (out_ready),
    .valid_out (valid_out),
    .data_out  (data_out),
    .owner_out (owner_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_a = 1'b1; req_b = 1'b1;
    field_a = 8'h11; field_b = 8'h22;
    wide_a = 1'b0; wide_b = 1'b0; signed_a = 1'b0; signed_b = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    checks++; if (gnt_a !== 1'b0) begin failures++; $display("FAIL reset_gnt_a got=%b exp=0", gnt_a); end
    checks++; if (gnt_b !== 1'b0) begin failures++; $display("FAIL reset_gnt_b got=%b exp=0", gnt_b); end
    checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_out); end
    checks++; if (data_out !== 16'h0000) begin failures++; $display("FAIL reset_data got=%h exp=0000", data_out); end
    checks++; if (owner_out !== 1'b0) begin failures++; $display("FAIL reset_owner got=%b exp=0", owner_out); end
    reset = 1'b0; req_a = 1'b0; req_b = 1'b0;
    #1;
  endtask

  task automatic test_a_only();
    req_a = 1'b1; field_a = 8'h0B; wide_a = 1'b0; signed_a = 1'b1;
    #1;
    checks++; if (gnt_a !== 1'b1) begin failures++; $display("FAIL a_only_gnt_a got=%b exp=1", gnt_a); end
    checks++; if (gnt_b !== 1'b0) begin failures++; $display("FAIL a_only_gnt_b got=%b exp=0", gnt_b); end
    tick();
    req_a = 1'b0;
    checks++; if (valid_out !== 1'b1) begin failures++; $display("FAIL a_only_valid got=%b exp=1", valid_out); end
    checks++; if (data_out !== 16'hFFFB) begin failures++; $display("FAIL a_only_data got=%h exp=FFFB", data_out); end
    checks++; if (owner_out !== 1'b0) begin failures++; $display("FAIL a_only_owner got=%b exp=0", owner_out); end
  endtask

  task automatic test_ext_matrix();
    logic [7:0]  f [4] = '{8'h80, 8'h80, 8'hFA, 8'h17};
    logic        w [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic        s [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [15:0] e [4] = '{16'hFF80, 16'h0080, 16'h000A, 16'h0007};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_b = 1'b1; field_b = f[i]; wide_b = w[i]; signed_b = s[i];
      #1;
      checks++; if (gnt_b !== 1'b1) begin failures++; $display("FAIL ext_gnt_b[%0d] got=%b exp=1", i, gnt_b); end
      tick();
      checks++; if (data_out !== e[i]) begin failures++; $display("FAIL ext_data[%0d] got=%h exp=%h", i, data_out, e[i]); end
      checks++; if (owner_out !== 1'b1) begin failures++; $display("FAIL ext_owner[%0d] got=%b exp=1", i, owner_out); end
    end
    req_b = 1'b0;
  endtask

  // Last grant before this is B, so A wins first.
  task automatic test_contention();
    logic        exp_b [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [15:0] exp_d [4] = '{16'h0001, 16'h0002, 16'h0001, 16'h0002};
    req_a = 1'b1; field_a = 8'h01; wide_a = 1'b0; signed_a = 1'b0;
    req_b = 1'b1; field_b = 8'h02; wide_b = 1'b0; signed_b = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (gnt_a !== !exp_b[i]) begin failures++; $display("FAIL cont_gnt_a[%0d] got=%b exp=%b", i, gnt_a, !exp_b[i]); end
      checks++; if (gnt_b !== exp_b[i]) begin failures++; $display("FAIL cont_gnt_b[%0d] got=%b exp=%b", i, gnt_b, exp_b[i]); end
      tick();
      checks++; if (owner_out !== exp_b[i]) begin failures++; $display("FAIL cont_owner[%0d] got=%b exp=%b", i, owner_out, exp_b[i]); end
      checks++; if (data_out !== exp_d[i]) begin failures++; $display("FAIL cont_data[%0d] got=%h exp=%h", i, data_out, exp_d[i]); end
    end
    req_a = 1'b0; req_b = 1'b0;
    tick();
    checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL drain_valid got=%b exp=0", valid_out); end
    checks++; if (data_out !== 16'h0002) begin failures++; $display("FAIL drain_data_hold got=%h exp=0002", data_out); end
  endtask

  task automatic test_backpressure();
    req_b = 1'b1; field_b = 8'h80; wide_b = 1'b1; signed_b = 1'b1;
    out_ready = 1'b1;
    tick();
    req_b = 1'b0; out_ready = 1'b0;
    req_a = 1'b1; field_a = 8'h05; wide_a = 1'b0; signed_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if ({gnt_a, gnt_b} !== 2'b00) begin failures++; $display("FAIL stall_gnt[%0d] got=%b%b exp=00", i, gnt_a, gnt_b); end
      tick();
      checks++; if (valid_out !== 1'b1) begin failures++; $display("FAIL stall_valid[%0d] got=%b exp=1", i, valid_out); end
      checks++; if (data_out !== 16'hFF80) begin failures++; $display("FAIL stall_data[%0d] got=%h exp=FF80", i, data_out); end
      checks++; if (owner_out !== 1'b1) begin failures++; $display("FAIL stall_owner[%0d] got=%b exp=1", i, owner_out); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (gnt_a !== 1'b1) begin failures++; $display("FAIL release_gnt_a got=%b exp=1", gnt_a); end
    tick();
    req_a = 1'b0;
    checks++; if (valid_out !== 1'b1) begin failures++; $display("FAIL release_valid got=%b exp=1", valid_out); end
    checks++; if (data_out !== 16'h0005) begin failures++; $display("FAIL release_data got=%h exp=0005", data_out); end
    checks++; if (owner_out !== 1'b0) begin failures++; $display("FAIL release_owner got=%b exp=0", owner_out); end
  endtask

  // Last grant is A, so only a reset can make A win the next contention.
  task automatic test_reset_stall();
    out_ready = 1'b0;
    tick();
    checks++; if (valid_out !== 1'b1) begin failures++; $display("FAIL pre_reset_valid got=%b exp=1", valid_out); end
    reset = 1'b1;
    req_a = 1'b1; req_b = 1'b1;
    field_a = 8'h03; wide_a = 1'b0; signed_a = 1'b0;
    field_b = 8'h04; wide_b = 1'b0; signed_b = 1'b0;
    #1;
    checks++; if ({gnt_a, gnt_b} !== 2'b00) begin failures++; $display("FAIL in_reset_gnt got=%b%b exp=00", gnt_a, gnt_b); end
    tick();
    checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL post_reset_valid got=%b exp=0", valid_out); end
    reset = 1'b0; out_ready = 1'b1;
    #1;
    checks++; if (gnt_a !== 1'b1) begin failures++; $display("FAIL post_reset_gnt_a got=%b exp=1", gnt_a); end
    checks++; if (gnt_b !== 1'b0) begin failures++; $display("FAIL post_reset_gnt_b got=%b exp=0", gnt_b); end
    tick();
    req_a = 1'b0; req_b = 1'b0;
    checks++; if (data_out !== 16'h0003) begin failures++; $display("FAIL post_reset_data got=%h exp=0003", data_out); end
  endtask

  initial begin
    test_reset();
    test_a_only();
    test_ext_matrix();
    test_contention();
    test_backpressure();
    test_reset_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_ext_arbiter
